// File: rtl/alarm_clock_ctrl.sv
// Alarm clock timekeeping/setting controller: one-second prescaler, seconds
// counter, RUN/SET_TIME/SET_ALARM mode machine and BCD HH:MM time/alarm registers.
module alarm_clock_ctrl #(
  parameter int CLK_PER_SEC = 50000000,
  parameter int PRE_W       = 26
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        set_time_key,
  input  logic        set_alarm_key,
  input  logic        hour_key,
  input  logic        minute_key,
  output logic [15:0] current_time,
  output logic [15:0] alarm_time,
  output logic        show_alarm,
  output logic        sec_tick,
  output logic [1:0]  mode
);

  typedef enum logic [1:0] {
    MODE_RUN       = 2'b00,
    MODE_SET_TIME  = 2'b01,
    MODE_SET_ALARM = 2'b10
  } mode_t;

  mode_t             r_mode;
  mode_t             w_mode_next;
  logic [PRE_W-1:0]  r_pre;
  logic [5:0]        r_sec;
  logic [15:0]       r_cur;
  logic [15:0]       r_alm;
  logic              r_tick;
  logic              r_show;
  logic              r_hour_prev;
  logic              r_min_prev;

  logic              w_hour_edge;
  logic              w_min_edge;
  logic              w_wrap;
  logic              w_counting;
  logic              w_min_roll;
  logic [15:0]       w_cur_next;
  logic [15:0]       w_alm_next;

  // BCD minute increment 00..59, wrapping without carry-out
  function automatic logic [7:0] inc_min(input logic [7:0] m);
    if (m[3:0] == 4'd9) begin
      if (m[7:4] == 4'd5) return 8'h00;
      return {m[7:4] + 4'd1, 4'd0};
    end
    return {m[7:4], m[3:0] + 4'd1};
  endfunction

  // BCD hour increment 00..23
  function automatic logic [7:0] inc_hour(input logic [7:0] h);
    if (h == 8'h23) return 8'h00;
    if (h[3:0] == 4'd9) return {h[7:4] + 4'd1, 4'd0};
    return {h[7:4], h[3:0] + 4'd1};
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) r_mode <= MODE_RUN;
    else        r_mode <= w_mode_next;
  end

  always_comb begin
    w_mode_next = MODE_RUN;
    if (set_alarm_key)     w_mode_next = MODE_SET_ALARM;
    else if (set_time_key) w_mode_next = MODE_SET_TIME;
  end

  assign w_hour_edge = hour_key & ~r_hour_prev;
  assign w_min_edge  = minute_key & ~r_min_prev;
  assign w_wrap      = (r_pre == PRE_W'(CLK_PER_SEC - 1));
  assign w_counting  = (w_mode_next != MODE_SET_TIME);
  assign w_min_roll  = w_counting && w_wrap && (r_sec == 6'd59);

  // Rollover and edits are decoded against the next mode, so they never collide
  always_comb begin
    w_cur_next = r_cur;
    w_alm_next = r_alm;
    if (w_min_roll) begin
      w_cur_next[7:0] = inc_min(r_cur[7:0]);
      if (r_cur[7:0] == 8'h59) w_cur_next[15:8] = inc_hour(r_cur[15:8]);
    end
    if (w_mode_next == MODE_SET_TIME) begin
      if (w_hour_edge) w_cur_next[15:8] = inc_hour(r_cur[15:8]);
      if (w_min_edge)  w_cur_next[7:0]  = inc_min(r_cur[7:0]);
    end
    if (w_mode_next == MODE_SET_ALARM) begin
      if (w_hour_edge) w_alm_next[15:8] = inc_hour(r_alm[15:8]);
      if (w_min_edge)  w_alm_next[7:0]  = inc_min(r_alm[7:0]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pre       <= '0;
      r_sec       <= '0;
      r_cur       <= '0;
      r_alm       <= '0;
      r_tick      <= 1'b0;
      r_show      <= 1'b0;
      r_hour_prev <= 1'b0;
      r_min_prev  <= 1'b0;
    end else begin
      r_hour_prev <= hour_key;
      r_min_prev  <= minute_key;
      r_show      <= (w_mode_next == MODE_SET_ALARM);
      r_cur       <= w_cur_next;
      r_alm       <= w_alm_next;
      r_tick      <= 1'b0;
      if (!w_counting) begin
        r_pre <= '0;
        r_sec <= '0;
      end else if (w_wrap) begin
        r_pre  <= '0;
        r_tick <= 1'b1;
        r_sec  <= (r_sec == 6'd59) ? 6'd0 : r_sec + 6'd1;
      end else begin
        r_pre <= r_pre + PRE_W'(1);
      end
    end
  end

  assign current_time = r_cur;
  assign alarm_time   = r_alm;
  assign show_alarm   = r_show;
  assign sec_tick     = r_tick;
  assign mode         = r_mode;

endmodule

// File: tb/tb_alarm_clock_ctrl.sv
// Self-checking bench: directed scenarios plus random key traffic, compared
// every cycle against a minutes-of-day reference model.
module tb_alarm_clock_ctrl;

  localparam int CPS = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        set_time_key = 1'b0;
  logic        set_alarm_key = 1'b0;
  logic        hour_key = 1'b0;
  logic        minute_key = 1'b0;
  logic [15:0] current_time;
  logic [15:0] alarm_time;
  logic        show_alarm;
  logic        sec_tick;
  logic [1:0]  mode;

  alarm_clock_ctrl #(.CLK_PER_SEC(CPS), .PRE_W(3)) dut (
    .clk          (clk),
    .reset        (rst_n),
    .set_time_key (set_time_key),
    .set_alarm_key(set_alarm_key),
    .hour_key     (hour_key),
    .minute_key   (minute_key),
    .current_time (current_time),
    .alarm_time   (alarm_time),
    .show_alarm   (show_alarm),
    .sec_tick     (sec_tick),
    .mode         (mode)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // reference model: times kept as minutes since midnight
  int m_pre = 0, m_sec = 0, m_cur = 0, m_alm = 0, m_mode = 0;
  int m_tick = 0, m_hprev = 0, m_mprev = 0;
  int tick_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int mins);
    int h, m;
    h = mins / 60;
    m = mins % 60;
    return 16'((h / 10) * 4096 + (h % 10) * 256 + (m / 10) * 16 + (m % 10));
  endfunction

  function automatic int add_hour(input int mins);
    return ((mins / 60 + 1) % 24) * 60 + mins % 60;
  endfunction

  function automatic int add_min(input int mins);
    return (mins / 60) * 60 + (mins % 60 + 1) % 60;
  endfunction

  task automatic model_edge();
    int nm, he, me;
    if (!rst_n) begin
      m_pre = 0; m_sec = 0; m_cur = 0; m_alm = 0; m_mode = 0;
      m_tick = 0; m_hprev = 0; m_mprev = 0;
      return;
    end
    nm = set_alarm_key ? 2 : (set_time_key ? 1 : 0);
    he = (hour_key && !m_hprev) ? 1 : 0;
    me = (minute_key && !m_mprev) ? 1 : 0;
    m_tick = 0;
    if (nm == 1) begin
      m_pre = 0;
      m_sec = 0;
      if (he != 0) m_cur = add_hour(m_cur);
      if (me != 0) m_cur = add_min(m_cur);
    end else begin
      m_pre = m_pre + 1;
      if (m_pre == CPS) begin
        m_pre = 0;
        m_tick = 1;
        m_sec = m_sec + 1;
        if (m_sec == 60) begin
          m_sec = 0;
          m_cur = (m_cur + 1) % 1440;
        end
      end
      if (nm == 2) begin
        if (he != 0) m_alm = add_hour(m_alm);
        if (me != 0) m_alm = add_min(m_alm);
      end
    end
    m_mode = nm;
    m_hprev = int'(hour_key);
    m_mprev = int'(minute_key);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("cur", 32'(current_time), 32'(to_bcd(m_cur)));
    check("alm", 32'(alarm_time), 32'(to_bcd(m_alm)));
    check("mode", 32'(mode), 32'(m_mode));
    check("show", 32'(show_alarm), 32'(m_mode == 2));
    check("tick", 32'(sec_tick), 32'(m_tick));
    if (sec_tick) tick_cnt++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_hour(input int n);
    for (int i = 0; i < n; i++) begin
      hour_key = 1'b1; step();
      hour_key = 1'b0; step();
    end
  endtask

  task automatic pulse_min(input int n);
    for (int i = 0; i < n; i++) begin
      minute_key = 1'b1; step();
      minute_key = 1'b0; step();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; step();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [15:0] held;
    // 1: free run from reset
    rst_n = 1'b0; steps(2);
    check("rst_cur", 32'(current_time), 32'h0);
    check("rst_mode", 32'(mode), 32'h0);
    rst_n = 1'b1;
    tick_cnt = 0;
    steps(240);
    check("t1_ticks", 32'(tick_cnt), 32'd60);
    check("t1_time", 32'(current_time), 32'h0001);
    check("t1_mode", 32'(mode), 32'h0);
    $display("run 240 cycles: time=%h ticks=%0d", current_time, tick_cnt);

    // 2: set 23:59 then roll over
    do_reset();
    set_time_key = 1'b1; step();
    tick_cnt = 0;
    pulse_hour(23);
    pulse_min(59);
    check("t2_set", 32'(current_time), 32'h2359);
    check("t2_mode", 32'(mode), 32'h1);
    check("t2_noticks", 32'(tick_cnt), 32'd0);
    set_time_key = 1'b0;
    steps(240);
    check("t2_roll", 32'(current_time), 32'h0000);
    $display("set 23:59 and run: time=%h", current_time);

    // 3: both keys held -> alarm edit while time keeps running
    set_alarm_key = 1'b1; set_time_key = 1'b1; step();
    pulse_hour(7);
    pulse_min(30);
    check("t3_alm", 32'(alarm_time), 32'h0730);
    check("t3_show", 32'(show_alarm), 32'h1);
    check("t3_mode", 32'(mode), 32'h2);
    steps(240);
    check("t3_run", 32'(current_time), 32'h0001);
    set_alarm_key = 1'b0; set_time_key = 1'b0; step();
    $display("alarm set: alarm=%h time=%h", alarm_time, current_time);

    // 4: minute wrap does not carry into hour
    do_reset();
    set_time_key = 1'b1; step();
    pulse_hour(10);
    pulse_min(59);
    check("t4_pre", 32'(current_time), 32'h1059);
    pulse_min(1);
    check("t4_wrap", 32'(current_time), 32'h1000);
    set_time_key = 1'b0; step();
    $display("minute wrap: time=%h", current_time);

    // 5: simultaneous hour and minute edge
    do_reset();
    set_time_key = 1'b1; step();
    hour_key = 1'b1; minute_key = 1'b1; step();
    check("t5_both", 32'(current_time), 32'h0101);
    hour_key = 1'b0; minute_key = 1'b0; set_time_key = 1'b0; step();
    $display("dual edge: time=%h", current_time);

    // 6: edge in RUN is consumed, held key gives no increment later
    do_reset();
    hour_key = 1'b1; step();
    held = current_time;
    set_time_key = 1'b1; steps(3);
    check("t6_noinc", 32'(current_time), 32'(held));
    check("t6_mode", 32'(mode), 32'h1);
    hour_key = 1'b0; set_time_key = 1'b0; step();
    $display("run-mode edge: time=%h", current_time);

    // 7: reset mid SET_ALARM
    set_alarm_key = 1'b1; step();
    pulse_hour(3);
    rst_n = 1'b0; step();
    check("t7_cur", 32'(current_time), 32'h0);
    check("t7_alm", 32'(alarm_time), 32'h0);
    check("t7_show", 32'(show_alarm), 32'h0);
    check("t7_tick", 32'(sec_tick), 32'h0);
    check("t7_mode", 32'(mode), 32'h0);
    rst_n = 1'b1; set_alarm_key = 1'b0; step();
    $display("reset in set-alarm: time=%h alarm=%h", current_time, alarm_time);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if (i % 50 == 0) begin
        set_time_key  = ($urandom_range(0, 2) == 0);
        set_alarm_key = ($urandom_range(0, 3) == 0);
      end
      hour_key   = ($urandom_range(0, 9) < 3);
      minute_key = ($urandom_range(0, 9) < 4);
      rst_n      = ($urandom_range(0, 599) != 0);
      step();
    end
    $display("random phase: time=%h alarm=%h", current_time, alarm_time);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
